// File: rtl/spm_program_loader.sv
// Wishbone-fed loader for the RISC_SPM external memory port: buffers (addr,data)
// pairs in a small FIFO, replays them as ext_write pulses, and supports single-byte readback.
module spm_program_loader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int WRITE_PULSE = 1,
    parameter int SETTLE      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ext_write,
    output logic [7:0]  address_bus,
    output logic [7:0]  data_bus,
    input  logic [7:0]  memory_bus,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_RSETTLE, S_RCAP
    } state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_timer;
    logic [15:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_addr, r_data, r_rdaddr, r_rdbyte;
    logic          r_pend, r_rdvalid;
    logic          w_req, w_accept, w_push, w_pop, w_empty, w_full, w_wr_rdaddr;
    logic [1:0]    w_sel;
    logic [31:0]   w_rdval;
    logic          w_unused;

    assign w_unused = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_sel   = wbs_adr_i[3:2];
    assign w_req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    // Backpressure: hold off WDATA while full and RDADDR while a read is outstanding.
    assign w_accept = w_req
                    & ~(wbs_we_i & (w_sel == 2'd0) & w_full)
                    & ~(wbs_we_i & (w_sel == 2'd2) & r_pend);
    assign w_push      = w_accept & wbs_we_i & (w_sel == 2'd0);
    assign w_wr_rdaddr = w_accept & wbs_we_i & (w_sel == 2'd2);
    assign w_pop       = (w_next == S_SETUP);

    assign busy        = (r_state != S_IDLE) | ~w_empty | r_pend;
    assign address_bus = r_addr;
    assign data_bus    = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= (w_next != r_state) ? 4'd0 : r_timer + 4'd1;
        end
    end

    // Writes always win over a pending read, so reads observe every earlier write.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty)    w_next = S_SETUP;
                else if (r_pend) w_next = S_RSETTLE;
            end
            S_SETUP:   w_next = S_PULSE;
            S_PULSE:   if (r_timer == 4'(WRITE_PULSE - 1)) w_next = S_HOLD;
            S_HOLD:    w_next = w_empty ? S_IDLE : S_SETUP;
            S_RSETTLE: if (r_timer == 4'(SETTLE - 1)) w_next = S_RCAP;
            S_RCAP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ext_write = 1'b0;
        case (r_state)
            S_PULSE: ext_write = 1'b1;
            default: ext_write = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= wbs_dat_i[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_rdaddr  <= '0;
            r_rdbyte  <= '0;
            r_pend    <= 1'b0;
            r_rdvalid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr <= r_fifo[r_rptr][15:8];
                r_data <= r_fifo[r_rptr][7:0];
            end else if (w_next == S_RSETTLE && r_state != S_RSETTLE) begin
                r_addr <= r_rdaddr;
            end
            if (w_wr_rdaddr) begin
                r_rdaddr  <= wbs_dat_i[7:0];
                r_pend    <= 1'b1;
                r_rdvalid <= 1'b0;
            end else if (r_state == S_RCAP) begin
                r_rdbyte  <= memory_bus;
                r_pend    <= 1'b0;
                r_rdvalid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdval = '0;
        case (w_sel)
            2'd1:    w_rdval = {23'd0, 5'(r_count), r_rdvalid, w_full, w_empty, busy};
            2'd3:    w_rdval = {24'd0, r_rdbyte};
            default: w_rdval = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= w_accept;
            wbs_dat_o <= (w_accept && !wbs_we_i) ? w_rdval : 32'd0;
        end
    end

endmodule
